pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage datapath, replacing the fixed-field stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries a control bundle and a data bundle separately, tracks a valid bit, and supports stall (hold) and flush (bubble insertion) with defined priority. Optional saturating performance counters record stall and bubble cycles per stage.

---
 rtl/pipe_stage_reg.sv | 90 +++++++++
 tb/tb_pipe_stage_reg.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: valid + control + payload, with stall/flush.
// Optional saturating stall/bubble counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_reg #(
    parameter int                  DATA_W   = 96,
    parameter int                  CTRL_W   = 8,
    parameter logic [CTRL_W-1:0]   CTRL_RST = '0,
    parameter int                  CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
`ifdef PIPE_PERF_CNT_EN
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
`endif
    output logic              ready_out
);

    logic              valid_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic [DATA_W-1:0] data_d;

    // Flush wins over stall, so upstream may advance whenever a flush is pending.
    assign ready_out = !stall || flush;

    // NOTE: every always_comb output gets a default first; a missing branch would infer a latch.
    always_comb begin
        valid_d = valid_out;
        ctrl_d  = ctrl_out;
        data_d  = data_out;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_RST;
        end else if (!stall) begin
            valid_d = valid_in;
            // A bubble never carries live control, so its write enables cannot fire.
            ctrl_d  = valid_in ? ctrl_in : CTRL_RST;
            data_d  = data_in;
        end
    end

    // NOTE: the wide payload is reset too; it is a flop bank, not a RAM, and reset keeps sim and silicon aligned.
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            ctrl_out  <= CTRL_RST;
            data_out  <= '0;
        end else begin
            valid_out <= valid_d;
            ctrl_out  <= ctrl_d;
            data_out  <= data_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic stall_ev;
    logic bubble_ev;

    assign stall_ev  = stall && !flush;
    assign bubble_ev = flush || (!stall && !valid_in);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic ev);
        return (ev && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

    // Clear beats increment; counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            stall_cnt  <= sat_inc(stall_cnt, stall_ev);
            bubble_cnt <= sat_inc(bubble_cnt, bubble_ev);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, corner sequences, random vs model.
// Counter checks are compiled only when PIPE_PERF_CNT_EN is defined.
module tb_pipe_stage_reg;

    localparam int          DATA_W   = 96;
    localparam int          CTRL_W   = 8;
    localparam logic [7:0]  CTRL_RST = 8'h5A;
    localparam int          CNT_W    = 4;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              flush;
    logic              valid_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic [DATA_W-1:0] data_in;
    logic              valid_out;
    logic [CTRL_W-1:0] ctrl_out;
    logic [DATA_W-1:0] data_out;
    logic              ready_out;
`ifdef PIPE_PERF_CNT_EN
    logic              cnt_clr;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .CTRL_RST(CTRL_RST),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .valid_in  (valid_in),
        .ctrl_in   (ctrl_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ctrl_out  (ctrl_out),
        .data_out  (data_out),
`ifdef PIPE_PERF_CNT_EN
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
`endif
        .ready_out (ready_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the stage holds, and how many events were seen.
    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    int                m_stall_n;
    int                m_bubble_n;

    typedef struct {
        logic              st;
        logic              fl;
        logic              vi;
        logic [CTRL_W-1:0] ci;
        logic [DATA_W-1:0] di;
        logic              ev;
        logic [CTRL_W-1:0] ec;
        logic [DATA_W-1:0] ed;
        logic              er;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid    = 1'b0;
        m_ctrl     = CTRL_RST;
        m_data     = '0;
        m_stall_n  = 0;
        m_bubble_n = 0;
    endtask

    task automatic model_edge(input logic st, input logic fl, input logic vi,
                              input logic [CTRL_W-1:0] ci, input logic [DATA_W-1:0] di,
                              input logic clr);
        if (clr) begin
            m_stall_n  = 0;
            m_bubble_n = 0;
        end else begin
            if (st && !fl) m_stall_n = (m_stall_n < CNT_MAX) ? m_stall_n + 1 : CNT_MAX;
            if (fl || (!st && !vi)) m_bubble_n = (m_bubble_n < CNT_MAX) ? m_bubble_n + 1 : CNT_MAX;
        end
        if (fl) begin
            m_valid = 1'b0;
            m_ctrl  = CTRL_RST;
        end else if (!st) begin
            m_valid = vi;
            m_ctrl  = vi ? ci : CTRL_RST;
            m_data  = di;
        end
    endtask

    // Apply inputs at the falling edge, check ready, then advance one rising edge.
    task automatic cycle(input logic st, input logic fl, input logic vi,
                         input logic [CTRL_W-1:0] ci, input logic [DATA_W-1:0] di,
                         input logic clr);
        @(negedge clk);
        stall    = st;
        flush    = fl;
        valid_in = vi;
        ctrl_in  = ci;
        data_in  = di;
`ifdef PIPE_PERF_CNT_EN
        cnt_clr  = clr;
`endif
        #1;
        check("ready_out", {127'b0, ready_out}, {127'b0, (!st || fl)});
        @(posedge clk);
        model_edge(st, fl, vi, ci, di, clr);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, {127'b0, valid_out}, {127'b0, m_valid});
        check({tag, ".ctrl"}, {120'b0, ctrl_out}, {120'b0, m_ctrl});
        check({tag, ".data"}, {32'b0, data_out}, {32'b0, m_data});
`ifdef PIPE_PERF_CNT_EN
        check({tag, ".stall_cnt"}, {124'b0, stall_cnt}, 128'(m_stall_n));
        check({tag, ".bubble_cnt"}, {124'b0, bubble_cnt}, 128'(m_bubble_n));
`endif
    endtask

    initial begin
        logic [CTRL_W-1:0] held_ctrl;
        logic [DATA_W-1:0] held_data;

        //           st    fl    vi    ctrl   data        exp_v exp_c   exp_d       ready
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'h11, 96'h1,     1'b1, 8'h11,  96'h1,      1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h22, 96'h2,     1'b1, 8'h22,  96'h2,      1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h33, 96'h3,     1'b1, 8'h33,  96'h3,      1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h44, 96'h4,     1'b1, 8'h44,  96'h4,      1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 96'h5,     1'b1, 8'h3C,  96'h5,      1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h77, 96'h6,     1'b1, 8'h3C,  96'h5,      1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'h88, 96'h7,     1'b1, 8'h3C,  96'h5,      1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h99, 96'h8,     1'b0, CTRL_RST, 96'h5,    1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'hFF, 96'h9,     1'b0, CTRL_RST, 96'h9,    1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 96'hA,     1'b1, 8'hFF,  96'hA,      1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h12, 96'hB,     1'b0, CTRL_RST, 96'hA,    1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h34, 96'hC,     1'b1, 8'h34,  96'hC,      1'b1};

        rst      = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        valid_in = 1'b0;
        ctrl_in  = '0;
        data_in  = '0;
`ifdef PIPE_PERF_CNT_EN
        cnt_clr  = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        rst = 1'b0;

        // Vector table: stage contents checked against hand-derived constants.
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].st, vecs[i].fl, vecs[i].vi, vecs[i].ci, vecs[i].di, 1'b0);
            check($sformatf("vec%0d.ready", i), {127'b0, ready_out}, {127'b0, vecs[i].er});
            check($sformatf("vec%0d.valid", i), {127'b0, valid_out}, {127'b0, vecs[i].ev});
            check($sformatf("vec%0d.ctrl", i), {120'b0, ctrl_out}, {120'b0, vecs[i].ec});
            check($sformatf("vec%0d.data", i), {32'b0, data_out}, {32'b0, vecs[i].ed});
        end
        check_model("after_table");

        // Asynchronous reset mid-stream, asserted between edges.
        cycle(1'b0, 1'b0, 1'b1, 8'hA5, 96'h1234, 1'b0);
        check_model("pre_async_rst");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_model("async_rst");
        @(posedge clk);
        #1;
        check_model("rst_held");
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b1, 8'hC3, 96'hDEAD_BEEF, 1'b0);
        check("first_edge.ctrl", {120'b0, ctrl_out}, 128'hC3);
        check("first_edge.data", {32'b0, data_out}, 128'hDEAD_BEEF);

        // Long stall with changing inputs: outputs must stay bit-identical; counter saturates.
        cycle(1'b0, 1'b0, 1'b1, 8'h3C, 96'hF00D, 1'b1);
        held_ctrl = ctrl_out;
        held_data = data_out;
        check("stall_load.ctrl", {120'b0, held_ctrl}, 128'h3C);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, i[0], 8'(i * 7), 96'(i * 1001), 1'b0);
            check("stall_hold.valid", {127'b0, valid_out}, 128'h1);
            check("stall_hold.ctrl", {120'b0, ctrl_out}, {120'b0, held_ctrl});
            check("stall_hold.data", {32'b0, data_out}, {32'b0, held_data});
`ifdef PIPE_PERF_CNT_EN
            if (i == 4) check("stall_cnt_5", {124'b0, stall_cnt}, 128'd5);
`endif
        end
`ifdef PIPE_PERF_CNT_EN
        check("stall_cnt_sat", {124'b0, stall_cnt}, 128'(CNT_MAX));
`endif
        // Clear while still stalling: clear wins over the increment.
        cycle(1'b1, 1'b0, 1'b1, 8'h01, 96'h1, 1'b1);
        check_model("clr_during_stall");
`ifdef PIPE_PERF_CNT_EN
        check("stall_cnt_clr", {124'b0, stall_cnt}, 128'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic st;
            logic fl;
            logic vi;
            logic cl;
            st = ($urandom_range(0, 9) < 3);
            fl = ($urandom_range(0, 9) < 1);
            vi = ($urandom_range(0, 9) < 7);
            cl = ($urandom_range(0, 49) == 0);
            cycle(st, fl, vi, 8'($urandom), {$urandom, $urandom, $urandom}, cl);
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
